id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS datapath.
- Sits between decode and execute.
- Its registered EX_Rs/EX_Rt feed the forwarding unit's Rs/Rt inputs; its EX_RegWrite/EX_Rd become the EX/MEM write-back tags one stage later.
- Stalls PC and IF/ID and inserts a bubble on a load-use hazard.
- Inserts a bubble on branch flush.
- Counts stall cycles for SAD benchmark profiling.

Parameters:
DATA_WIDTH, 32, width of register-file operands and sign-extended immediate
CNT_WIDTH, 16, width of saturating stall counter

Ports:
Clk  in  1  system clock, rising edge
Rst  in  1  asynchronous, active-high reset
ID_RegWrite  in  1  decode control: writes register file
ID_MemRead  in  1  decode control: load
ID_MemWrite  in  1  decode control: store
ID_MemToReg  in  1  decode control: write-back select
ID_ALUSrc  in  1  decode control: immediate operand select
ID_RegDst  in  1  decode control: Rd (1) vs Rt (0) destination
ID_ALUOp  in  4  decode ALU operation
ID_ReadData1  in  DATA_WIDTH  register-file Rs value
ID_ReadData2  in  DATA_WIDTH  register-file Rt value
ID_Imm  in  DATA_WIDTH  sign-extended immediate
ID_Rs, ID_Rt, ID_Rd  in  5 each  decoded register numbers
ID_UsesRt  in  1  instruction actually reads Rt as a source
Flush  in  1  branch taken; squash instruction in decode
EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_ALUSrc, EX_RegDst  out  1 each  registered controls
EX_ALUOp  out  4  registered ALU op
EX_ReadData1, EX_ReadData2, EX_Imm  out  DATA_WIDTH  registered operands
EX_Rs, EX_Rt, EX_Rd  out  5 each  registered register numbers (to forwarding unit)
PCWrite  out  1  PC update enable (combinational)
IFIDWrite  out  1  IF/ID register enable (combinational)
Stall  out  1  load-use hazard this cycle (combinational)
StallCount  out  CNT_WIDTH  saturating count of stall cycles

Behaviour:
- Reset (async, Rst=1): every EX_* output is 0; StallCount is 0. PCWrite/IFIDWrite are 1 and Stall is 0, because all EX_* are 0.
- Hazard, combinational: Stall = EX_MemRead & (EX_Rt != 0) & ((EX_Rt == ID_Rs) | (ID_UsesRt & (EX_Rt == ID_Rt))).
- PCWrite = IFIDWrite = ~Stall | Flush. When Flush=1 the fetch redirect must proceed.
- Register update on rising Clk: if Stall | Flush, load a bubble, i.e. all EX_* fields = 0 (controls, data and register numbers).
- Otherwise all EX_* = corresponding ID_* values; latency is exactly 1 cycle.
- A bubble has EX_RegWrite=0 and EX_MemRead=0. A load-use stall therefore lasts exactly one cycle; the decode instruction re-evaluates and advances on the next cycle.
- Flush and Stall together: bubble, PCWrite=1, IFIDWrite=1. StallCount still increments, because Stall is asserted.
- StallCount: +1 on each rising edge with Stall=1 and Rst=0. It saturates at all-ones and does not wrap.
- Rst asserted mid-stall: outputs clear immediately. The stalled decode instruction is the IF/ID owner's responsibility.
- No X propagation: all EX_* outputs are driven from flops with defined reset.

Decomposition:
- Shared package/header holds:
  - ALUOp encoding constants (4-bit);
  - REG_ZERO = 5'd0;
  - control-bundle field width constant (7 single-bit/bit-field controls plus ALUOp).
- One sub-module, load_use_detect: the combinational Stall equation. It is reused by the integration bench for checking.
- Pipeline register and counter stay in id_ex_stage.

Test Plan:
1. Reset: Rst=1 mid-traffic -> all EX_*=0, StallCount=0 immediately (async); Rst=0 -> PCWrite=1, Stall=0.
2. lw $8 then add $9,$8,$10 (ID_Rs=8): EX_MemRead=1, EX_Rt=8 -> Stall=1, PCWrite=0, IFIDWrite=0. Next edge gives EX_RegWrite=0 (bubble), StallCount=1. Following edge: add latched with EX_Rs=8, EX_Rt=10.
3. lw $0 then add using $0 -> Stall=0; add latched next edge, StallCount unchanged.
4. lw $8 then instruction with ID_Rt=8, ID_UsesRt=0 -> no stall; with ID_UsesRt=1 -> Stall=1.
5. Flush=1 with hazard present -> bubble latched, PCWrite=1, IFIDWrite=1, StallCount +1. Flush=1 alone -> bubble, count unchanged.
6. CNT_WIDTH=4, force 20 hazard cycles -> StallCount holds 15 and never wraps to 0.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared constants and types for the ID/EX pipeline register and its hazard detector.
package id_ex_stage_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_NOR = 4'd5;
  localparam logic [3:0] ALU_SLT = 4'd6;
  localparam logic [3:0] ALU_SLL = 4'd7;
  localparam logic [3:0] ALU_SRL = 4'd8;
  localparam logic [3:0] ALU_LUI = 4'd9;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Seven control fields: six flags plus the 4-bit ALUOp.
  localparam int unsigned CTRL_FIELDS = 7;
  localparam int unsigned CTRL_WIDTH  = 10;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_dst;
    logic [3:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: a load in EX whose target is read by decode.
module load_use_detect
  import id_ex_stage_pkg::*;
(
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_rt,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_id_uses_rt,
  output logic       o_stall
);

  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit = (i_ex_rt == i_id_rs);
  assign w_rt_hit = i_id_uses_rt && (i_ex_rt == i_id_rt);
  assign o_stall  = i_ex_mem_read && (i_ex_rt != REG_ZERO) && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush bubbles and a saturating stall counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  ID_RegWrite,
  input  logic                  ID_MemRead,
  input  logic                  ID_MemWrite,
  input  logic                  ID_MemToReg,
  input  logic                  ID_ALUSrc,
  input  logic                  ID_RegDst,
  input  logic [3:0]            ID_ALUOp,
  input  logic [DATA_WIDTH-1:0] ID_ReadData1,
  input  logic [DATA_WIDTH-1:0] ID_ReadData2,
  input  logic [DATA_WIDTH-1:0] ID_Imm,
  input  logic [4:0]            ID_Rs,
  input  logic [4:0]            ID_Rt,
  input  logic [4:0]            ID_Rd,
  input  logic                  ID_UsesRt,
  input  logic                  Flush,
  output logic                  EX_RegWrite,
  output logic                  EX_MemRead,
  output logic                  EX_MemWrite,
  output logic                  EX_MemToReg,
  output logic                  EX_ALUSrc,
  output logic                  EX_RegDst,
  output logic [3:0]            EX_ALUOp,
  output logic [DATA_WIDTH-1:0] EX_ReadData1,
  output logic [DATA_WIDTH-1:0] EX_ReadData2,
  output logic [DATA_WIDTH-1:0] EX_Imm,
  output logic [4:0]            EX_Rs,
  output logic [4:0]            EX_Rt,
  output logic [4:0]            EX_Rd,
  output logic                  PCWrite,
  output logic                  IFIDWrite,
  output logic                  Stall,
  output logic [CNT_WIDTH-1:0]  StallCount
);

  ctrl_t                 r_ctrl;
  logic [DATA_WIDTH-1:0] r_rd1;
  logic [DATA_WIDTH-1:0] r_rd2;
  logic [DATA_WIDTH-1:0] r_imm;
  logic [4:0]            r_rs;
  logic [4:0]            r_rt;
  logic [4:0]            r_rd;
  logic [CNT_WIDTH-1:0]  r_stall_cnt;

  ctrl_t w_id_ctrl;
  logic  w_stall;
  logic  w_bubble;

  assign w_id_ctrl = '{
    reg_write:  ID_RegWrite,
    mem_read:   ID_MemRead,
    mem_write:  ID_MemWrite,
    mem_to_reg: ID_MemToReg,
    alu_src:    ID_ALUSrc,
    reg_dst:    ID_RegDst,
    alu_op:     ID_ALUOp
  };

  load_use_detect u_load_use_detect (
    .i_ex_mem_read (r_ctrl.mem_read),
    .i_ex_rt       (r_rt),
    .i_id_rs       (ID_Rs),
    .i_id_rt       (ID_Rt),
    .i_id_uses_rt  (ID_UsesRt),
    .o_stall       (w_stall)
  );

  // A taken branch must redirect fetch even while a load-use hazard is pending.
  assign w_bubble  = w_stall || Flush;
  assign PCWrite   = !w_stall || Flush;
  assign IFIDWrite = !w_stall || Flush;
  assign Stall     = w_stall;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_ctrl <= '0;
      r_rd1  <= '0;
      r_rd2  <= '0;
      r_imm  <= '0;
      r_rs   <= '0;
      r_rt   <= '0;
      r_rd   <= '0;
    end else if (w_bubble) begin
      r_ctrl <= '0;
      r_rd1  <= '0;
      r_rd2  <= '0;
      r_imm  <= '0;
      r_rs   <= '0;
      r_rt   <= '0;
      r_rd   <= '0;
    end else begin
      r_ctrl <= w_id_ctrl;
      r_rd1  <= ID_ReadData1;
      r_rd2  <= ID_ReadData2;
      r_imm  <= ID_Imm;
      r_rs   <= ID_Rs;
      r_rt   <= ID_Rt;
      r_rd   <= ID_Rd;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_WIDTH{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
    end
  end

  assign EX_RegWrite  = r_ctrl.reg_write;
  assign EX_MemRead   = r_ctrl.mem_read;
  assign EX_MemWrite  = r_ctrl.mem_write;
  assign EX_MemToReg  = r_ctrl.mem_to_reg;
  assign EX_ALUSrc    = r_ctrl.alu_src;
  assign EX_RegDst    = r_ctrl.reg_dst;
  assign EX_ALUOp     = r_ctrl.alu_op;
  assign EX_ReadData1 = r_rd1;
  assign EX_ReadData2 = r_rd2;
  assign EX_Imm       = r_imm;
  assign EX_Rs        = r_rs;
  assign EX_Rt        = r_rt;
  assign EX_Rd        = r_rd;
  assign StallCount   = r_stall_cnt;

endmodule
